// File: rtl/addr8s_accum_pkg.sv
// addr8s_accum_pkg: shared types and constants for the burst accumulator.
//   state_e  - controller states (ACC collects samples, HOLD presents result)
//   DATA_W   - sample / accumulator width
//   SUM_W    - adder result width (one guard bit for overflow detection)
//   SAT_MAX / SAT_MIN - clamp values used when saturation is enabled
package addr8s_accum_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int DATA_W = 8;
    localparam int SUM_W  = 9;

    localparam logic [DATA_W-1:0] SAT_MAX = 8'h7F;  // +127
    localparam logic [DATA_W-1:0] SAT_MIN = 8'h80;  // -128

endpackage

// File: rtl/addr8s_cell.sv
// addr8s_cell: combinational 8-bit signed adder with a 9-bit result.
//   A[7:0] - signed operand
//   B[7:0] - signed operand
//   O[8:0] - signed sum, wide enough to never overflow
module addr8s_cell
    import addr8s_accum_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [SUM_W-1:0]  O
);

    // Sign-extend both operands so O[8] is the true sign of the sum.
    assign O = {A[DATA_W-1], A} + {B[DATA_W-1], B};

endmodule

// File: rtl/addr8s_accum_ctrl.sv
// addr8s_accum_ctrl: sums BURST_LEN signed samples and hands the result
// downstream over a valid/ready handshake.
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - sample handshake, in_data is the signed sample
//   out_valid/out_ready - result handshake
//   out_data          - signed burst sum (clamped or wrapped per SATURATE)
//   out_ovf           - some add in the burst left the 8-bit range
//   out_mismatch      - the duplicated adders disagreed during the burst
module addr8s_accum_ctrl
    import addr8s_accum_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int SATURATE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf,
    output logic              out_mismatch
);

    localparam int CNT_W = $clog2(BURST_LEN);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                mm_q, mm_d;

    logic [SUM_W-1:0]    sum_a;
    logic [SUM_W-1:0]    sum_b;
    logic                accept;
    logic                add_ovf;
    logic [DATA_W-1:0]   add_res;

    // Primary adder feeds the accumulator; secondary only cross-checks it.
    addr8s_cell u_cell_a (.A(acc_q), .B(in_data), .O(sum_a));
    addr8s_cell u_cell_b (.A(acc_q), .B(in_data), .O(sum_b));

    assign accept  = in_valid && (state_q == ACC);
    assign add_ovf = sum_a[SUM_W-1] ^ sum_a[SUM_W-2];

    // On overflow the guard bit holds the true sign: 1 means negative overflow.
    always_comb begin
        add_res = sum_a[DATA_W-1:0];
        if (SATURATE != 0 && add_ovf)
            add_res = sum_a[SUM_W-1] ? SAT_MIN : SAT_MAX;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        mm_d    = mm_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d   = add_res;
                    count_d = count_q + 1'b1;
                    ovf_d   = ovf_q | add_ovf;
                    mm_d    = mm_q | (sum_a != sum_b);
                    if (count_q == CNT_W'(BURST_LEN - 1))
                        state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACC;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    mm_d    = 1'b0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            mm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            mm_q    <= mm_d;
        end
    end

    // All outputs come straight from registers: no in_data-to-output path.
    assign in_ready     = (state_q == ACC);
    assign out_valid    = (state_q == HOLD);
    assign out_data     = acc_q;
    assign out_ovf      = ovf_q;
    assign out_mismatch = mm_q;

endmodule

// File: tb/tb_addr8s_accum_ctrl.sv
// tb_addr8s_accum_ctrl: drives a saturating and a wrapping instance with the
// same directed bursts; expected results are queued per instance at issue
// time and a monitor compares them on each output handshake.
module tb_addr8s_accum_ctrl;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic       mm;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready0, out_valid0, out_ovf0, out_mm0;
    logic [7:0] out_data0;
    logic       in_ready1, out_valid1, out_ovf1, out_mm1;
    logic [7:0] out_data1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    addr8s_accum_ctrl #(.BURST_LEN(4), .SATURATE(1)) u_dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_ovf(out_ovf0), .out_mismatch(out_mm0)
    );

    addr8s_accum_ctrl #(.BURST_LEN(4), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_ovf(out_ovf1), .out_mismatch(out_mm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one pop per completed output handshake per instance.
    always @(negedge clk) begin
        if (!rst && out_ready) begin
            if (out_valid0) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sat_unexpected_result: data 0x%0h with empty queue", out_data0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("sat_data", {24'd0, out_data0}, {24'd0, e.data});
                    chk("sat_ovf",  {31'd0, out_ovf0},  {31'd0, e.ovf});
                    chk("sat_mm",   {31'd0, out_mm0},   {31'd0, e.mm});
                end
            end
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wrap_unexpected_result: data 0x%0h with empty queue", out_data1);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("wrap_data", {24'd0, out_data1}, {24'd0, e.data});
                    chk("wrap_ovf",  {31'd0, out_ovf1},  {31'd0, e.ovf});
                    chk("wrap_mm",   {31'd0, out_mm1},   {31'd0, e.mm});
                end
            end
        end
    end

    // Feed n samples; when push is set, queue expected results first.
    // force_idx selects a sample during which the saturating instance's
    // secondary adder is overridden with force_val.
    task automatic send(input logic [7:0] s [4], input int n, input bit push,
                        input exp_t e0, input exp_t e1,
                        input int force_idx, input logic [8:0] force_val);
        if (push) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        for (int i = 0; i < n; i++) begin
            int wait_cyc;
            wait_cyc = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = s[i];
            while (!in_ready0) begin
                @(negedge clk);
                wait_cyc++;
                if (wait_cyc > 50) begin
                    checks++; errors++;
                    $display("FAIL accept_timeout: sample %0d never accepted", i);
                    in_valid = 1'b0;
                    return;
                end
            end
            if (i == force_idx) force u_dut_sat.sum_b = force_val;
            @(posedge clk);
            #1;
            if (i == force_idx) release u_dut_sat.sum_b;
            in_valid = 1'b0;
        end
        if (n == 4) begin
            // Result must be up exactly one edge after the final accept.
            chk("latency_out_valid", {31'd0, out_valid0}, 32'd1);
            chk("latency_in_ready",  {31'd0, in_ready0},  32'd0);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic o, input logic m);
        exp_t e;
        e.data = d; e.ovf = o; e.mm = m;
        return e;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready0},  32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid0}, 32'd0);
        chk({tag, "_out_data"},  {24'd0, out_data0},  32'd0);
        chk({tag, "_out_ovf"},   {31'd0, out_ovf0},   32'd0);
        chk({tag, "_out_mm"},    {31'd0, out_mm0},    32'd0);
        chk({tag, "_wrap_data"}, {24'd0, out_data1},  32'd0);
        chk({tag, "_wrap_vld"},  {31'd0, out_valid1}, 32'd0);
    endtask

    initial begin
        int guard;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");

        // 10+20+30+40 = 100 in both modes
        send('{8'd10, 8'd20, 8'd30, 8'd40}, 4, 1'b1,
             mk(8'd100, 0, 0), mk(8'd100, 0, 0), -1, 9'd0);
        // 100+100 overflows: clamp to 127 vs wrap to 200-256 = -56
        send('{8'd100, 8'd100, 8'd0, 8'd0}, 4, 1'b1,
             mk(8'h7F, 1, 0), mk(8'hC8, 1, 0), -1, 9'd0);
        // -100-100 = -200: clamp -128 then -129 clamps again; wrap 56, 55
        send('{8'h9C, 8'h9C, 8'hFF, 8'h00}, 4, 1'b1,
             mk(8'h80, 1, 0), mk(8'h37, 1, 0), -1, 9'd0);
        // -128-128 = -256: clamp -128; wrap to 0
        send('{8'h80, 8'h80, 8'h00, 8'h00}, 4, 1'b1,
             mk(8'h80, 1, 0), mk(8'h00, 1, 0), -1, 9'd0);
        // 127+1: clamp 127 then 126; wrap -128, -129 wraps again to 127
        send('{8'h7F, 8'h01, 8'hFF, 8'h00}, 4, 1'b1,
             mk(8'h7E, 1, 0), mk(8'h7F, 1, 0), -1, 9'd0);

        // Backpressure: hold result 5+6+7+8 = 26 for 5 cycles
        @(posedge clk); #1 out_ready = 1'b0;
        send('{8'd5, 8'd6, 8'd7, 8'd8}, 4, 1'b1,
             mk(8'd26, 0, 0), mk(8'd26, 0, 0), -1, 9'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_out_valid", {31'd0, out_valid0}, 32'd1);
            chk("hold_out_data",  {24'd0, out_data0},  32'd26);
            chk("hold_in_ready",  {31'd0, in_ready0},  32'd0);
            chk("hold_wrap_data", {24'd0, out_data1},  32'd26);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send('{8'd1, 8'd2, 8'd3, 8'd4}, 4, 1'b1,
             mk(8'd10, 0, 0), mk(8'd10, 0, 0), -1, 9'd0);

        // Reset mid-burst discards the partial sum
        send('{8'd50, 8'd50, 8'd0, 8'd0}, 2, 1'b0,
             mk(8'd0, 0, 0), mk(8'd0, 0, 0), -1, 9'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_idle("midreset");
        send('{8'd1, 8'd1, 8'd1, 8'd1}, 4, 1'b1,
             mk(8'd4, 0, 0), mk(8'd4, 0, 0), -1, 9'd0);

        // Secondary adder corrupted on 2nd accept: 3+3 = 6, O[0] flipped -> 7
        send('{8'd3, 8'd3, 8'd3, 8'd3}, 4, 1'b1,
             mk(8'd12, 0, 1), mk(8'd12, 0, 0), 1, 9'd7);
        // Clean burst clears the sticky mismatch: 7-7+1+2 = 3
        send('{8'd7, 8'hF9, 8'd1, 8'd2}, 4, 1'b1,
             mk(8'd3, 0, 0), mk(8'd3, 0, 0), -1, 9'd0);

        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        chk("sat_queue_drained",  q0.size(), 32'd0);
        chk("wrap_queue_drained", q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
